cond_unit_pipe: RTL

- Pipelined successor to the single-cycle conditional-write logic in the ARM processor.
- Registers decode-stage control into the Execute stage and evaluates the 4-bit condition code there against one of NUM_FSETS NZCV flag sets.
- Gates register, memory and PC writes, updates the selected flag set, and carries the gated controls through the Memory and Writeback stages.
- Sits between the control unit and the hazard unit; BranchTakenE drives the hazard unit's flush logic.

---
 rtl/cond_pkg.sv | 37 +++
 rtl/cond_eval.sv | 46 ++++
 rtl/cond_unit_pipe.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/cond_pkg.sv
// Shared types for the pipelined conditional-execution unit.
// Holds the ARM condition-code enum, the NZCV flag bit positions, the flag
// word type and the control bundle that travels from Decode into Execute.
package cond_pkg;

    typedef enum logic [3:0] {
        EQ = 4'h0, NE = 4'h1, CS = 4'h2, CC = 4'h3,
        MI = 4'h4, PL = 4'h5, VS = 4'h6, VC = 4'h7,
        HI = 4'h8, LS = 4'h9, GE = 4'hA, LT = 4'hB,
        GT = 4'hC, LE = 4'hD, AL = 4'hE, NV = 4'hF
    } cond_e;

    localparam int N_IDX = 3;
    localparam int Z_IDX = 2;
    localparam int C_IDX = 1;
    localparam int V_IDX = 0;

    typedef logic [3:0] flags_t;

    // Flag-set selector storage width inside the control bundle. Wide enough
    // for any practical NUM_FSETS; the top zero-extends its narrower selector.
    localparam int FSEL_MAX_W = 8;

    typedef struct packed {
        logic                  valid;
        logic                  pcs;
        logic                  regw;
        logic                  memw;
        logic                  memtoreg;
        logic [1:0]            flagw;
        cond_e                 cond;
        logic [FSEL_MAX_W-1:0] fsel;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/cond_eval.sv
// Combinational ARM condition-code evaluator.
// Ports:
//   cond_i   - 4-bit condition field
//   flags_i  - {N,Z,C,V} flag word to test against
//   condex_o - 1 when the condition holds
module cond_eval
    import cond_pkg::*;
(
    input  cond_e  cond_i,
    input  flags_t flags_i,
    output logic   condex_o
);

    logic n, z, c, v;

    assign n = flags_i[N_IDX];
    assign z = flags_i[Z_IDX];
    assign c = flags_i[C_IDX];
    assign v = flags_i[V_IDX];

    // NOTE: combinational blocks assign a default first so no path can
    // leave the output unassigned and infer a latch.
    always_comb begin
        condex_o = 1'b1;
        case (cond_i)
            EQ: condex_o = z;
            NE: condex_o = !z;
            CS: condex_o = c;
            CC: condex_o = !c;
            MI: condex_o = n;
            PL: condex_o = !n;
            VS: condex_o = v;
            VC: condex_o = !v;
            HI: condex_o = c && !z;
            LS: condex_o = !c || z;
            GE: condex_o = (n == v);
            LT: condex_o = (n != v);
            GT: condex_o = !z && (n == v);
            LE: condex_o = z || (n != v);
            AL: condex_o = 1'b1;
            NV: condex_o = 1'b1;   // treated as always, like AL
            default: condex_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/cond_unit_pipe.sv
// Pipelined conditional-write unit. Registers decode controls into Execute,
// evaluates the condition against one of NUM_FSETS NZCV flag sets, gates the
// register/memory/PC writes, updates the selected flag set and carries the
// gated controls through Memory and Writeback.
// Ports:
//   clk, reset (async, active-high); EnE stage advance; FlushE bubble insert
//   CondD/FlagWD/FSelD/PCSD/RegWD/MemWD/MemtoRegD/ValidD decode controls
//   ALUFlagsE  ALU flags of the Execute instruction
//   *E/*M/*W   gated controls per stage; BranchTakenE flush request
//   FlagsOut   all flag sets, set k at [4k+3:4k]
//   StatExec/StatSquash saturating counters, present only with COND_STATS_EN
// Optional feature macro: COND_STATS_EN
module cond_unit_pipe
    import cond_pkg::*;
#(
    parameter  int NUM_FSETS = 1,
    parameter  int CNT_W     = 16,
    localparam int FSEL_W    = (NUM_FSETS > 1) ? $clog2(NUM_FSETS) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   EnE,
    input  logic                   FlushE,
    input  logic [3:0]             CondD,
    input  logic [1:0]             FlagWD,
    input  logic [FSEL_W-1:0]      FSelD,
    input  logic                   PCSD,
    input  logic                   RegWD,
    input  logic                   MemWD,
    input  logic                   MemtoRegD,
    input  logic                   ValidD,
    input  logic [3:0]             ALUFlagsE,
    output logic                   PCSrcE,
    output logic                   RegWriteE,
    output logic                   MemWriteE,
    output logic                   BranchTakenE,
    output logic                   RegWriteM,
    output logic                   MemWriteM,
    output logic                   MemtoRegM,
    output logic                   PCSrcM,
    output logic                   RegWriteW,
    output logic                   MemtoRegW,
    output logic                   PCSrcW,
    output logic [4*NUM_FSETS-1:0] FlagsOut
`ifdef COND_STATS_EN
    ,
    output logic [CNT_W-1:0]       StatExec,
    output logic [CNT_W-1:0]       StatSquash
`endif
);

    if (NUM_FSETS < 1 || FSEL_W > FSEL_MAX_W) begin : g_bad_fsets
        $error("cond_unit_pipe: NUM_FSETS out of supported range");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("cond_unit_pipe: CNT_W must be at least 1");
    end

    localparam logic [FSEL_MAX_W-1:0] NUM_FSETS_V = FSEL_MAX_W'(NUM_FSETS);

    ctrl_t  ctrl_d, ctrl_q;
    flags_t flags_d [NUM_FSETS];
    flags_t flags_q [NUM_FSETS];
    flags_t flags_sel;
    logic   fsel_ok, cond_true, cond_ex, commit;

    always_comb begin
        ctrl_d          = CTRL_BUBBLE;
        ctrl_d.valid    = ValidD;
        ctrl_d.pcs      = PCSD;
        ctrl_d.regw     = RegWD;
        ctrl_d.memw     = MemWD;
        ctrl_d.memtoreg = MemtoRegD;
        ctrl_d.flagw    = FlagWD;
        ctrl_d.cond     = cond_e'(CondD);
        ctrl_d.fsel     = FSEL_MAX_W'(FSelD);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_q <= CTRL_BUBBLE;
        end else if (EnE) begin
            ctrl_q <= FlushE ? CTRL_BUBBLE : ctrl_d;
        end
    end

    // An out-of-range selector reads as all-zero flags and is squashed below.
    always_comb begin
        flags_sel = '0;
        for (int k = 0; k < NUM_FSETS; k++) begin
            if (ctrl_q.fsel == FSEL_MAX_W'(k)) flags_sel = flags_q[k];
        end
    end

    assign fsel_ok = (ctrl_q.fsel < NUM_FSETS_V);

    cond_eval u_cond_eval (
        .cond_i   (ctrl_q.cond),
        .flags_i  (flags_sel),
        .condex_o (cond_true)
    );

    assign cond_ex      = cond_true && fsel_ok;
    assign commit       = ctrl_q.valid && cond_ex;
    assign RegWriteE    = ctrl_q.regw && commit;
    assign MemWriteE    = ctrl_q.memw && commit;
    assign PCSrcE       = ctrl_q.pcs  && commit;
    assign BranchTakenE = PCSrcE;

    // Flags written at the edge that retires the instruction from Execute are
    // what the next Execute instruction reads, so no bypass is needed.
    always_comb begin
        flags_d = flags_q;
        if (EnE && commit) begin
            for (int k = 0; k < NUM_FSETS; k++) begin
                if (ctrl_q.fsel == FSEL_MAX_W'(k)) begin
                    if (ctrl_q.flagw[1]) flags_d[k][N_IDX:Z_IDX] = ALUFlagsE[N_IDX:Z_IDX];
                    if (ctrl_q.flagw[0]) flags_d[k][C_IDX:V_IDX] = ALUFlagsE[C_IDX:V_IDX];
                end
            end
        end
    end

    // NOTE: the flag array is architectural state that must read as zero
    // after reset, so unlike a data memory every entry is reset here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NUM_FSETS; k++) flags_q[k] <= '0;
        end else begin
            flags_q <= flags_d;
        end
    end

    always_comb begin
        FlagsOut = '0;
        for (int k = 0; k < NUM_FSETS; k++) FlagsOut[4*k +: 4] = flags_q[k];
    end

    // Memory and Writeback copies; MemtoReg travels ungated.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            RegWriteM <= 1'b0;
            MemWriteM <= 1'b0;
            MemtoRegM <= 1'b0;
            PCSrcM    <= 1'b0;
            RegWriteW <= 1'b0;
            MemtoRegW <= 1'b0;
            PCSrcW    <= 1'b0;
        end else if (EnE) begin
            RegWriteM <= RegWriteE;
            MemWriteM <= MemWriteE;
            MemtoRegM <= ctrl_q.memtoreg;
            PCSrcM    <= PCSrcE;
            RegWriteW <= RegWriteM;
            MemtoRegW <= MemtoRegM;
            PCSrcW    <= PCSrcM;
        end
    end

`ifdef COND_STATS_EN
    logic [CNT_W-1:0] stat_exec_q, stat_squash_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_exec_q   <= '0;
            stat_squash_q <= '0;
        end else if (EnE && ctrl_q.valid) begin
            if (cond_ex) begin
                if (stat_exec_q != '1) stat_exec_q <= stat_exec_q + 1'b1;
            end else begin
                if (stat_squash_q != '1) stat_squash_q <= stat_squash_q + 1'b1;
            end
        end
    end

    assign StatExec   = stat_exec_q;
    assign StatSquash = stat_squash_q;
`endif

endmodule
